serial_pattern_matcher: RTL
===========================

# serial_pattern_matcher

Bit-serial pattern matcher that sits directly downstream of the XNOR gate level. It shifts an incoming serial stream into a WIDTH-bit window. Each cycle it compares the window against a loaded reference pattern using a bank of XNOR gates reduced by AND. It emits a one-cycle match pulse per accepted bit that completes a matching window, and optionally counts matches. Typical uses are sync-word and preamble detection in front of a deserialiser.

## Interface
Parameters:
- WIDTH, 8, pattern/window length in bits (≥2)
- COUNT_W, 8, match counter width (used only with the counter feature)

Ports:
- clk  in  1  rising-edge clock; one clock domain
- rst_n  in  1  reset, synchronous, active-low
- load  in  1  capture pattern_in; restart fill
- pattern_in  in  WIDTH  reference pattern, sampled only when load=1
- valid  in  1  din qualifier
- din  in  1  serial data bit
- match  out  1  registered pulse: accepted bit completed a matching window
- armed  out  1  WIDTH bits accepted since last reset/load
- window  out  WIDTH  current shift register contents; newest bit in LSB
- match_count  out  COUNT_W  saturating match count (see Configuration)

## Operation
- Two-state FSM:
  - FILL: reset/load state. Bit counter increments per accepted bit. Moves to ARMED on the bit that makes the count equal WIDTH.
  - ARMED: stays there until reset or load.
- A bit is accepted on a rising edge with valid=1 and load=0.
  - Shift: window ← {window[WIDTH-2:0], din}.
  - The stream is therefore MSB-first relative to pattern_in.
- Compare: eq = &(next_window ~^ pattern), evaluated on the post-shift window.
- match ← accepted & eq & (next state == ARMED).
- Overlapping matches are detected; there is no reset-on-match.
- valid=0: window, state and counter hold. match ← 0.
- load=1 (priority over valid):
  - pattern ← pattern_in; window ← 0; state ← FILL; bit counter ← 0; match ← 0; match_count ← 0.
  - din is discarded that cycle.
- Bit counter width is clog2(WIDTH+1). It saturates at WIDTH and never wraps.
- A pattern of all zeros cannot match during FILL, even though window resets to zero. The armed gate guarantees this.

## Timing
- rst_n=0 at an edge: pattern=0, window=0, state FILL, armed=0, match=0, match_count=0. Same behaviour when asserted mid-stream. Overrides load and valid.
- Latency: match is high for exactly the one cycle after the edge that accepted the completing bit.
- Back-to-back matches with valid held high give consecutive high cycles.
- armed rises in the cycle after the WIDTH-th accepted bit, together with any match for that bit.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- MATCH_COUNT_EN defined:
  - match_count increments on every cycle where match is set.
  - It saturates at 2^COUNT_W−1 and never wraps.
  - It is cleared by reset or load.
- MATCH_COUNT_EN undefined: no counter logic is built, and match_count is tied to 0. The port list is identical in both builds.

## Structure
- Shared package serial_pattern_pkg holds:
  - the FSM state typedef (FILL, ARMED)
  - the default WIDTH/COUNT_W constants
  - the bit-counter width function.
- One sub-module, xnor_compare (parameter WIDTH): bitwise XNOR of two vectors plus AND-reduce to eq. Built from the existing XNOR gate-level cell, one instance per bit.
- Top level holds the FSM, shift register, pattern register, match register and optional counter.

## Test plan
- Reset: hold rst_n=0 for 2 cycles mid-stream → window=0, armed=0, match=0, match_count=0 the cycle after.
- Basic match, WIDTH=8: load 8'hA5, feed 1,0,1,0,0,1,0,1 with valid=1 → match=1 exactly one cycle after the 8th bit, armed rises the same cycle, match_count=1.
- Overlap: load 8'hFF, feed ten 1s → match high for 3 consecutive cycles after bits 8–10, match_count=3.
- Fill guard and gaps:
  - load 8'h00, feed 7 zeros → no match.
  - Repeat the 8'hA5 case with valid dropped for 2 cycles between bits → window holds during gaps, match=0 in gaps, single match after the last bit.
- Priority: load=1 and valid=1 in the same cycle mid-stream → din dropped, window=0, armed=0, match_count=0.
- Saturation with COUNT_W=2, MATCH_COUNT_EN defined: 5 matches → match_count stays at 3. Without the macro → match_count=0 throughout.

Source files
------------

// File: rtl/serial_pattern_pkg.sv
// Shared types and constants for the serial pattern matcher.
package serial_pattern_pkg;

  typedef enum logic {
    FILL  = 1'b0,
    ARMED = 1'b1
  } state_e;

  localparam int DEFAULT_WIDTH   = 8;
  localparam int DEFAULT_COUNT_W = 8;

  // Bits needed to count 0..width inclusive.
  function automatic int bit_cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/serial_pattern_matcher_xnor_compare.sv
// Per-bit XNOR gate bank reduced by AND: eq_o is high when a_i equals b_i.
module xnor_compare #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             eq_o
);

  logic [WIDTH-1:0] bit_eq_s;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    xnor u_xnor (bit_eq_s[i], a_i[i], b_i[i]);
  end

  assign eq_o = &bit_eq_s;

endmodule

// File: rtl/serial_pattern_matcher.sv
// Bit-serial sync-word matcher with a fill/armed gate.
// Define MATCH_COUNT_EN to build the saturating match counter; otherwise match_count is 0.
module serial_pattern_matcher
  import serial_pattern_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int COUNT_W = DEFAULT_COUNT_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [WIDTH-1:0]   pattern_in,
  input  logic               valid,
  input  logic               din,
  output logic               match,
  output logic               armed,
  output logic [WIDTH-1:0]   window,
  output logic [COUNT_W-1:0] match_count
);

  localparam int                   CNT_W    = bit_cnt_w(WIDTH);
  localparam logic [CNT_W-1:0]     CNT_FULL = CNT_W'(WIDTH);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] pattern_q, pattern_d;
  logic [WIDTH-1:0] window_q, window_d;
  logic             match_q, match_d;
  logic [WIDTH-1:0] window_shift_s;
  logic             eq_s;

  assign window_shift_s = {window_q[WIDTH-2:0], din};

  // Compare the post-shift window so a match reports the bit just accepted.
  xnor_compare #(.WIDTH(WIDTH)) u_cmp (
    .a_i  (window_shift_s),
    .b_i  (pattern_q),
    .eq_o (eq_s)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= FILL;
      cnt_q     <= '0;
      pattern_q <= '0;
      window_q  <= '0;
      match_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pattern_q <= pattern_d;
      window_q  <= window_d;
      match_q   <= match_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pattern_d = pattern_q;
    window_d  = window_q;
    match_d   = 1'b0;
    if (load) begin
      state_d   = FILL;
      cnt_d     = '0;
      pattern_d = pattern_in;
      window_d  = '0;
    end else if (valid) begin
      window_d = window_shift_s;
      if (cnt_q != CNT_FULL) begin
        cnt_d = cnt_q + 1'b1;
      end else begin
        cnt_d = cnt_q;
      end
      case (state_q)
        FILL:    state_d = (cnt_d == CNT_FULL) ? ARMED : FILL;
        ARMED:   state_d = ARMED;
        default: state_d = FILL;
      endcase
      // The armed gate keeps an all-zero pattern from matching the cleared window.
      match_d = eq_s & (state_d == ARMED);
    end else begin
      match_d = 1'b0;
    end
  end

`ifdef MATCH_COUNT_EN
  logic [COUNT_W-1:0] count_q, count_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Counts alongside match_d so the count and the pulse appear together.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = '0;
    end else if (match_d && (count_q != {COUNT_W{1'b1}})) begin
      count_d = count_q + 1'b1;
    end else begin
      count_d = count_q;
    end
  end

  assign match_count = count_q;
`else
  assign match_count = '0;
`endif

  assign match  = match_q;
  assign armed  = (state_q == ARMED);
  assign window = window_q;

endmodule
